pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the fetch-control master and the PC sequencer.
interface pc_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  pc_load;
    logic                  exc;
    logic                  br_taken;
    logic [DATA_WIDTH-1:0] br_target;
    logic                  jmp;
    logic                  jmp_link;
    logic [DATA_WIDTH-1:0] jmp_target;
    logic                  ret;
    logic                  halt;
    logic                  resume;
    logic [DATA_WIDTH-1:0] cur_address;
    logic                  redirect;
    logic                  misalign;
    logic                  ras_underflow;
    logic                  ras_empty;
    logic                  ras_full;
    logic                  halted;

    modport slave (
        input  pc_load, exc, br_taken, br_target, jmp, jmp_link, jmp_target,
               ret, halt, resume,
        output cur_address, redirect, misalign, ras_underflow, ras_empty,
               ras_full, halted
    );

    modport master (
        output pc_load, exc, br_taken, br_target, jmp, jmp_link, jmp_target,
               ret, halt, resume,
        input  cur_address, redirect, misalign, ras_underflow, ras_empty,
               ras_full, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: sequential advance, prioritised redirects,
// deferred (stalled) redirects, halt/resume and a circular return-address stack.
module pc_sequencer #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           INC          = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = DATA_WIDTH'('h80),
    parameter int unsigned           RAS_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    localparam int unsigned           PTR_W      = $clog2(RAS_DEPTH);
    localparam int unsigned           CNT_W      = PTR_W + 1;
    localparam logic [DATA_WIDTH-1:0] INC_V      = DATA_WIDTH'(INC);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(INC_V - DATA_WIDTH'(1));
    localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {RUN, PEND, HALT} state_t;

    state_t                r_state, w_next_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_pend_tgt;
    logic                  r_pend_push, r_pend_pop;
    logic                  r_redirect, r_misalign, r_underflow, r_halted;
    logic [DATA_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]      r_wp;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_ras_empty, w_ras_full;
    logic [DATA_WIDTH-1:0] w_ras_top, w_ret_addr, w_req_tgt, w_tgt;
    logic                  w_req, w_req_push, w_req_pop;
    logic                  w_load, w_adv, w_push, w_pop, w_pend_wr, w_uf;

    assign w_ras_empty = (r_cnt == '0);
    assign w_ras_full  = (r_cnt == FULL_CNT);
    assign w_ras_top   = r_ras[r_wp - PTR_W'(1)];
    assign w_ret_addr  = r_pc + INC_V;

    // Select this cycle's redirect below exc; ret on an empty stack is no request.
    always_comb begin
        w_req      = 1'b0;
        w_req_tgt  = '0;
        w_req_push = 1'b0;
        w_req_pop  = 1'b0;
        if (bus.br_taken) begin
            w_req     = 1'b1;
            w_req_tgt = bus.br_target;
        end else if (bus.ret) begin
            w_req     = ~w_ras_empty;
            w_req_pop = ~w_ras_empty;
            w_req_tgt = w_ras_top;
        end else if (bus.jmp) begin
            w_req      = 1'b1;
            w_req_push = bus.jmp_link;
            w_req_tgt  = bus.jmp_target;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_next_state;
    end

    // Next state and per-cycle actions.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        w_tgt        = '0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_pend_wr    = 1'b0;
        w_uf         = 1'b0;
        case (r_state)
            RUN, PEND: begin
                if (bus.exc) begin
                    w_load       = 1'b1;
                    w_tgt        = EXC_VECTOR;
                    w_next_state = RUN;
                end else if (bus.halt) begin
                    w_next_state = HALT;
                end else begin
                    w_uf = bus.ret & ~bus.br_taken & w_ras_empty;
                    if (bus.pc_load) begin
                        w_next_state = RUN;
                        if (w_req) begin
                            w_load = 1'b1;
                            w_tgt  = w_req_tgt;
                            w_push = w_req_push;
                            w_pop  = w_req_pop;
                        end else if (r_state == PEND) begin
                            w_load = 1'b1;
                            w_tgt  = r_pend_tgt;
                            w_push = r_pend_push;
                            w_pop  = r_pend_pop;
                        end else begin
                            w_adv = 1'b1;
                        end
                    end else if (w_req) begin
                        w_pend_wr    = 1'b1;
                        w_next_state = PEND;
                    end
                end
            end
            HALT: begin
                if (bus.exc) begin
                    w_load       = 1'b1;
                    w_tgt        = EXC_VECTOR;
                    w_next_state = RUN;
                end else if (bus.resume) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    // PC, status pulses, pending redirect and stack pointer/count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_VECTOR;
            r_redirect  <= 1'b0;
            r_misalign  <= 1'b0;
            r_underflow <= 1'b0;
            r_halted    <= 1'b0;
            r_pend_tgt  <= '0;
            r_pend_push <= 1'b0;
            r_pend_pop  <= 1'b0;
            r_wp        <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_load)     r_pc <= w_tgt & ALIGN_MASK;
            else if (w_adv) r_pc <= r_pc + INC_V;
            r_redirect  <= w_load;
            r_misalign  <= w_load & (|(w_tgt & ~ALIGN_MASK));
            r_underflow <= w_uf;
            r_halted    <= (w_next_state == HALT);
            if (w_pend_wr) begin
                r_pend_tgt  <= w_req_tgt;
                r_pend_push <= w_req_push;
                r_pend_pop  <= w_req_pop;
            end
            if (w_push) begin
                r_wp <= r_wp + PTR_W'(1);
                if (!w_ras_full) r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop) begin
                r_wp  <= r_wp - PTR_W'(1);
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Stack storage; a push when full overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (!reset && w_push) r_ras[r_wp] <= w_ret_addr;
    end

    assign bus.cur_address   = r_pc;
    assign bus.redirect      = r_redirect;
    assign bus.misalign      = r_misalign;
    assign bus.ras_underflow = r_underflow;
    assign bus.ras_empty     = w_ras_empty;
    assign bus.ras_full      = w_ras_full;
    assign bus.halted        = r_halted;
endmodule
